// File: rtl/mem_access_unit.sv
// Memory-stage sequencer in front of a word-wide data memory: issues aligned
// read/write cycles, does read-modify-write for SB/SH and extends sub-word loads.
module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_tag,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              done,
  output logic              err,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic [4:0]        load_tag
);

  localparam logic [3:0] OP_SW = 4'b1011;

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

  state_t      state;
  logic [3:0]  op_q;
  logic [1:0]  off_q;
  logic [15:0] wdata_q;
  logic [4:0]  tag_q;
  logic        op_legal;
  logic        misaligned;

  // Shift amount that brings the addressed byte/half down to bit 0.
  function automatic logic [4:0] byte_shift(input logic [1:0] off);
    return BIG_ENDIAN ? {~off, 3'b000} : {off, 3'b000};
  endfunction

  function automatic logic [4:0] half_shift(input logic off1);
    return BIG_ENDIAN ? {~off1, 4'b0000} : {off1, 4'b0000};
  endfunction

  // op[2] selects zero-extension, op[1:0] the access size.
  function automatic logic [31:0] extract(input logic [2:0] op, input logic [1:0] off,
                                          input logic [31:0] word);
    logic [7:0]  b8;
    logic [15:0] h16;
    b8  = 8'(word >> byte_shift(off));
    h16 = 16'(word >> half_shift(off[1]));
    case (op[1:0])
      2'b00:   return op[2] ? {24'd0, b8} : {{24{b8[7]}}, b8};
      2'b01:   return op[2] ? {16'd0, h16} : {{16{h16[15]}}, h16};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic half, input logic [1:0] off,
                                        input logic [15:0] wd, input logic [31:0] word);
    logic [31:0] mask;
    logic [31:0] lane;
    if (half) begin
      mask = 32'h0000_FFFF << half_shift(off[1]);
      lane = {16'd0, wd} << half_shift(off[1]);
    end else begin
      mask = 32'h0000_00FF << byte_shift(off);
      lane = {24'd0, wd[7:0]} << byte_shift(off);
    end
    return (word & ~mask) | lane;
  endfunction

  always_comb begin
    case (req_op)
      4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101,
      4'b1000, 4'b1001, 4'b1011: op_legal = 1'b1;
      default:                   op_legal = 1'b0;
    endcase
    misaligned = ((req_op[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_op[1:0] == 2'b11) && (req_addr[1:0] != 2'b00));
  end

  assign req_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      load_valid <= 1'b0;
      load_data  <= '0;
      load_tag   <= '0;
    end else begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      load_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            off_q   <= req_addr[1:0];
            wdata_q <= req_wdata[15:0];
            tag_q   <= req_tag;
            if (!op_legal || misaligned) begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (req_op == OP_SW) begin
              state     <= S_WR;
              mem_write <= 1'b1;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_wdata <= req_wdata;
            end else begin
              state    <= S_RD;
              mem_read <= 1'b1;
              mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            end
          end
        end
        S_RD: state <= S_WAIT;
        // read data is on mem_rdata during this state only
        S_WAIT: begin
          if (op_q[3]) begin
            state     <= S_WR;
            mem_write <= 1'b1;
            mem_wdata <= merge(op_q[0], off_q, wdata_q, mem_rdata);
          end else begin
            state      <= S_DONE;
            done       <= 1'b1;
            load_valid <= 1'b1;
            load_data  <= extract(op_q[2:0], off_q, mem_rdata);
            load_tag   <= tag_q;
            mem_addr   <= '0;
          end
        end
        S_WR: begin
          state     <= S_DONE;
          done      <= 1'b1;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word memory model, expected-event scoreboard,
// one task per feature.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_tag;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        done;
  logic        err;
  logic        load_valid;
  logic [31:0] load_data;
  logic [4:0]  load_tag;

  typedef struct {
    int          rd_cyc;
    int          wr_cyc;
    int          done_cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic        lv;
    logic [31:0] ldata;
    logic [4:0]  ltag;
  } ev_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  tag;
    logic [31:0] res;
  } req_t;

  ev_t         exp_q[$];
  ev_t         obs;
  ev_t         e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_ld = '0;
  logic [4:0]  last_tag = '0;
  logic [31:0] mem [logic [31:0]];

  mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .done(done), .err(err),
    .load_valid(load_valid), .load_data(load_data), .load_tag(load_tag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_read) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'h5A5A_5A5A;
    if (mem_write) mem[mem_addr] = mem_wdata;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one request, then record every strobe until done (bounded).
  task automatic run_req(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] tag);
    obs = '{-1, -1, -1, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 5'd0};
    req_op = op; req_addr = addr; req_wdata = wdata; req_tag = tag; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      if (mem_read) begin
        obs.rd_cyc = (obs.rd_cyc < 0) ? c : 99;
        obs.addr = mem_addr;
      end
      if (mem_write) begin
        obs.wr_cyc = (obs.wr_cyc < 0) ? c : 99;
        obs.addr = mem_addr;
        obs.wdata = mem_wdata;
      end
      if (done) begin
        obs.done_cyc = c; obs.err = err; obs.lv = load_valid;
        obs.ldata = load_data; obs.ltag = load_tag;
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %b want 0", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (load_valid !== 1'b0) begin errors++; $display("FAIL reset_load_valid got %b want 0", load_valid); end
    checks++; if (load_data !== 32'd0) begin errors++; $display("FAIL reset_load_data got %h want 0", load_data); end
  endtask

  task automatic test_store_word();
    req_t t [2];
    t[0] = '{4'b1011, 32'h10, 32'hDEAD_BEEF, 5'd0, 32'd0};
    t[1] = '{4'b1011, 32'h10, 32'h8012_34F0, 5'd3, 32'd0};
    foreach (t[i]) begin
      exp_q.push_back('{-1, 1, 2, 32'h10, t[i].wdata, 1'b0, 1'b0, last_ld, last_tag});
      run_req(t[i].op, t[i].addr, t[i].wdata, t[i].tag);
      e = exp_q.pop_front();
      checks++; if (obs.rd_cyc !== e.rd_cyc) begin errors++; $display("FAIL sw%0d rd_cyc got %0d want %0d", i, obs.rd_cyc, e.rd_cyc); end
      checks++; if (obs.wr_cyc !== e.wr_cyc) begin errors++; $display("FAIL sw%0d wr_cyc got %0d want %0d", i, obs.wr_cyc, e.wr_cyc); end
      checks++; if (obs.done_cyc !== e.done_cyc) begin errors++; $display("FAIL sw%0d done_cyc got %0d want %0d", i, obs.done_cyc, e.done_cyc); end
      checks++; if (obs.addr !== e.addr) begin errors++; $display("FAIL sw%0d addr got %h want %h", i, obs.addr, e.addr); end
      checks++; if (obs.wdata !== e.wdata) begin errors++; $display("FAIL sw%0d wdata got %h want %h", i, obs.wdata, e.wdata); end
      checks++; if ({obs.err, obs.lv} !== {e.err, e.lv}) begin errors++; $display("FAIL sw%0d err_lv got %b%b want %b%b", i, obs.err, obs.lv, e.err, e.lv); end
      checks++; if ({obs.ldata, obs.ltag} !== {e.ldata, e.ltag}) begin errors++; $display("FAIL sw%0d hold got %h/%0d want %h/%0d", i, obs.ldata, obs.ltag, e.ldata, e.ltag); end
    end
  endtask

  task automatic test_loads();
    req_t t [8];
    t[0] = '{4'b0011, 32'h10, 32'd0, 5'd1,  32'h8012_34F0};
    t[1] = '{4'b0000, 32'h13, 32'd0, 5'd7,  32'hFFFF_FFF0};
    t[2] = '{4'b0100, 32'h10, 32'd0, 5'd2,  32'h0000_0080};
    t[3] = '{4'b0001, 32'h12, 32'd0, 5'd3,  32'h0000_34F0};
    t[4] = '{4'b0001, 32'h10, 32'd0, 5'd4,  32'hFFFF_8012};
    t[5] = '{4'b0101, 32'h10, 32'd0, 5'd5,  32'h0000_8012};
    t[6] = '{4'b0000, 32'h10, 32'd0, 5'd6,  32'hFFFF_FF80};
    t[7] = '{4'b0100, 32'h12, 32'd0, 5'd31, 32'h0000_0034};
    foreach (t[i]) begin
      exp_q.push_back('{1, -1, 3, 32'h10, 32'd0, 1'b0, 1'b1, t[i].res, t[i].tag});
      last_ld = t[i].res; last_tag = t[i].tag;
      run_req(t[i].op, t[i].addr, t[i].wdata, t[i].tag);
      e = exp_q.pop_front();
      checks++; if (obs.rd_cyc !== e.rd_cyc) begin errors++; $display("FAIL ld%0d rd_cyc got %0d want %0d", i, obs.rd_cyc, e.rd_cyc); end
      checks++; if (obs.wr_cyc !== e.wr_cyc) begin errors++; $display("FAIL ld%0d wr_cyc got %0d want %0d", i, obs.wr_cyc, e.wr_cyc); end
      checks++; if (obs.done_cyc !== e.done_cyc) begin errors++; $display("FAIL ld%0d done_cyc got %0d want %0d", i, obs.done_cyc, e.done_cyc); end
      checks++; if (obs.addr !== e.addr) begin errors++; $display("FAIL ld%0d addr got %h want %h", i, obs.addr, e.addr); end
      checks++; if ({obs.err, obs.lv} !== {e.err, e.lv}) begin errors++; $display("FAIL ld%0d err_lv got %b%b want %b%b", i, obs.err, obs.lv, e.err, e.lv); end
      checks++; if (obs.ldata !== e.ldata) begin errors++; $display("FAIL ld%0d load_data got %h want %h", i, obs.ldata, e.ldata); end
      checks++; if (obs.ltag !== e.ltag) begin errors++; $display("FAIL ld%0d load_tag got %0d want %0d", i, obs.ltag, e.ltag); end
    end
  endtask

  task automatic test_rmw();
    req_t t [2];
    t[0] = '{4'b1000, 32'h11, 32'h0000_00AA, 5'd0, 32'h80AA_34F0};
    t[1] = '{4'b1001, 32'h12, 32'hFFFF_5678, 5'd0, 32'h80AA_5678};
    foreach (t[i]) begin
      exp_q.push_back('{1, 3, 4, 32'h10, t[i].res, 1'b0, 1'b0, last_ld, last_tag});
      run_req(t[i].op, t[i].addr, t[i].wdata, t[i].tag);
      e = exp_q.pop_front();
      checks++; if (obs.rd_cyc !== e.rd_cyc) begin errors++; $display("FAIL rmw%0d rd_cyc got %0d want %0d", i, obs.rd_cyc, e.rd_cyc); end
      checks++; if (obs.wr_cyc !== e.wr_cyc) begin errors++; $display("FAIL rmw%0d wr_cyc got %0d want %0d", i, obs.wr_cyc, e.wr_cyc); end
      checks++; if (obs.done_cyc !== e.done_cyc) begin errors++; $display("FAIL rmw%0d done_cyc got %0d want %0d", i, obs.done_cyc, e.done_cyc); end
      checks++; if (obs.addr !== e.addr) begin errors++; $display("FAIL rmw%0d addr got %h want %h", i, obs.addr, e.addr); end
      checks++; if (obs.wdata !== e.wdata) begin errors++; $display("FAIL rmw%0d wdata got %h want %h", i, obs.wdata, e.wdata); end
      checks++; if ({obs.err, obs.lv} !== {e.err, e.lv}) begin errors++; $display("FAIL rmw%0d err_lv got %b%b want %b%b", i, obs.err, obs.lv, e.err, e.lv); end
    end
  endtask

  task automatic test_errors();
    req_t t [5];
    t[0] = '{4'b0011, 32'h12, 32'd0, 5'd9, 32'd0};
    t[1] = '{4'b1001, 32'h11, 32'h1234, 5'd0, 32'd0};
    t[2] = '{4'b0110, 32'h10, 32'd0, 5'd8, 32'd0};
    t[3] = '{4'b1111, 32'h10, 32'd0, 5'd8, 32'd0};
    t[4] = '{4'b0101, 32'h13, 32'd0, 5'd8, 32'd0};
    foreach (t[i]) begin
      exp_q.push_back('{-1, -1, 1, 32'd0, 32'd0, 1'b1, 1'b0, last_ld, last_tag});
      run_req(t[i].op, t[i].addr, t[i].wdata, t[i].tag);
      e = exp_q.pop_front();
      checks++; if ({obs.rd_cyc, obs.wr_cyc} !== {e.rd_cyc, e.wr_cyc}) begin errors++; $display("FAIL err%0d access rd %0d wr %0d want none", i, obs.rd_cyc, obs.wr_cyc); end
      checks++; if (obs.done_cyc !== e.done_cyc) begin errors++; $display("FAIL err%0d done_cyc got %0d want %0d", i, obs.done_cyc, e.done_cyc); end
      checks++; if ({obs.err, obs.lv} !== {e.err, e.lv}) begin errors++; $display("FAIL err%0d err_lv got %b%b want %b%b", i, obs.err, obs.lv, e.err, e.lv); end
      checks++; if ({obs.ldata, obs.ltag} !== {e.ldata, e.ltag}) begin errors++; $display("FAIL err%0d hold got %h/%0d want %h/%0d", i, obs.ldata, obs.ltag, e.ldata, e.ltag); end
    end
  endtask

  task automatic test_reset_mid_rmw();
    int wr_seen = 0;
    req_op = 4'b1001; req_addr = 32'h10; req_wdata = 32'h0000_1111; req_tag = '0; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_rmw mem_read got %b want 1", mem_read); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_rmw ready got %b want 1", req_ready); end
    checks++; if ({load_data, load_tag} !== 37'd0) begin errors++; $display("FAIL rst_rmw load got %h/%0d want 0/0", load_data, load_tag); end
    last_ld = '0; last_tag = '0;
    for (int c = 0; c < 6; c++) begin
      if (mem_write || done) wr_seen++;
      tick();
    end
    checks++; if (wr_seen !== 0) begin errors++; $display("FAIL rst_rmw late_write got %0d want 0", wr_seen); end
    exp_q.push_back('{1, -1, 3, 32'h10, 32'd0, 1'b0, 1'b1, 32'h80AA_5678, 5'd12});
    last_ld = 32'h80AA_5678; last_tag = 5'd12;
    run_req(4'b0011, 32'h10, 32'd0, 5'd12);
    e = exp_q.pop_front();
    checks++; if (obs.ldata !== e.ldata) begin errors++; $display("FAIL rst_rmw word got %h want %h", obs.ldata, e.ldata); end
    checks++; if (obs.done_cyc !== e.done_cyc) begin errors++; $display("FAIL rst_rmw done_cyc got %0d want %0d", obs.done_cyc, e.done_cyc); end
  endtask

  task automatic test_back_to_back();
    int nrd = 0, nwr = 0, rd_c = -1, wr_c = -1, done_c = -1, lv_c = -1, acc_c = -1;
    logic [2:0]  ready_bits = '0;
    logic [31:0] lv_data = '0;
    logic        drop;
    req_op = 4'b1011; req_addr = 32'h20; req_wdata = 32'h1111_1111; req_tag = '0; req_valid = 1'b1;
    tick();
    req_op = 4'b0011; req_addr = 32'h20; req_wdata = '0; req_tag = 5'd9;
    for (int c = 1; c <= 10; c++) begin
      drop = 1'b0;
      if (c <= 3) ready_bits[c-1] = req_ready;
      if (mem_read) begin nrd++; rd_c = c; end
      if (mem_write) begin nwr++; wr_c = c; end
      if (done && done_c < 0) done_c = c;
      if (load_valid) begin lv_c = c; lv_data = load_data; end
      if (req_ready && req_valid && acc_c < 0) begin acc_c = c; drop = 1'b1; end
      tick();
      if (drop) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    last_ld = 32'h1111_1111; last_tag = 5'd9;
    checks++; if (ready_bits !== 3'b100) begin errors++; $display("FAIL b2b ready got %b want 100", ready_bits); end
    checks++; if (acc_c !== 3) begin errors++; $display("FAIL b2b accept_cyc got %0d want 3", acc_c); end
    checks++; if ({nrd, nwr} !== {32'd1, 32'd1}) begin errors++; $display("FAIL b2b counts rd %0d wr %0d want 1 1", nrd, nwr); end
    checks++; if ({wr_c, done_c, rd_c} !== {32'd1, 32'd2, 32'd4}) begin errors++; $display("FAIL b2b cycles wr %0d done %0d rd %0d want 1 2 4", wr_c, done_c, rd_c); end
    checks++; if (lv_c !== 6) begin errors++; $display("FAIL b2b load_valid_cyc got %0d want 6", lv_c); end
    checks++; if (lv_data !== last_ld) begin errors++; $display("FAIL b2b load_data got %h want %h", lv_data, last_ld); end
  endtask

  initial begin
    mem_rdata = '0;
    test_reset();
    test_store_word();
    test_loads();
    test_rmw();
    test_errors();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
